// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl_pkg
//  Description : Shared definitions for the multiply/divide unit sequencer.
//                - MDU op encodings. They match the decoder ALUOP values
//                  used when aluSel=1.
//                - Sequencer state encodings.
//                - Default op latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    // MDU op encodings (ALUOP under aluSel=1)
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MFHI  = 3'd4;
    localparam logic [2:0] MD_MFLO  = 3'd5;
    localparam logic [2:0] MD_MTHI  = 3'd6;
    localparam logic [2:0] MD_MTLO  = 3'd7;

    // Sequencer states
    localparam logic [0:0] MDU_IDLE = 1'b0;
    localparam logic [0:0] MDU_BUSY = 1'b1;

    // Default latencies and the counter width that holds them (1..15)
    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;
    localparam int MDU_CNT_W           = 4;

    // Ops 0..3 are the long-latency multiply/divide ops.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Purely combinational HI/LO result generator.
//                Ports:
//                  op      [2:0]  MDU op
//                  rs, rt  [31:0] operands
//                  cur_hi, cur_lo [31:0] current architectural HI/LO
//                  next_hi, next_lo [31:0] resulting HI/LO for this op
//                Divide by zero holds the current HI/LO. mf ops also hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] next_hi,
    output logic [31:0] next_lo
);

    logic               w_rt_zero;
    logic               w_sdiv_ovf;
    logic [31:0]        w_sdiv_rt;
    logic [31:0]        w_udiv_rt;
    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic signed [31:0] w_squot;
    logic signed [31:0] w_srem;
    logic        [31:0] w_uquot;
    logic        [31:0] w_urem;

    assign w_rt_zero  = (rt == 32'd0);
    assign w_sdiv_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

    // The divisor is never zero and never -1 on the overflow case.
    // Dividing the most negative value by 1 already gives the required
    // wrap result: quotient 0x80000000, remainder 0.
    assign w_sdiv_rt = (w_rt_zero || w_sdiv_ovf) ? 32'd1 : rt;
    assign w_udiv_rt = w_rt_zero ? 32'd1 : rt;

    assign w_sprod = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign w_uprod = {32'd0, rs} * {32'd0, rt};
    assign w_squot = $signed(rs) / $signed(w_sdiv_rt);
    assign w_srem  = $signed(rs) % $signed(w_sdiv_rt);
    assign w_uquot = rs / w_udiv_rt;
    assign w_urem  = rs % w_udiv_rt;

    always_comb begin
        next_hi = cur_hi;
        next_lo = cur_lo;
        case (op)
            MD_MULT:  {next_hi, next_lo} = w_sprod;
            MD_MULTU: {next_hi, next_lo} = w_uprod;
            MD_DIV: begin
                if (!w_rt_zero) begin
                    next_hi = w_srem;
                    next_lo = w_squot;
                end
            end
            MD_DIVU: begin
                if (!w_rt_zero) begin
                    next_hi = w_urem;
                    next_lo = w_uquot;
                end
            end
            MD_MTHI: next_hi = rs;
            MD_MTLO: next_lo = rs;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multiply/divide unit sequencer and HI/LO register owner.
//                It runs ops with a fixed latency and drives the D-stage
//                stall.
//                Ports:
//                  clk, reset          clock and asynchronous active-high reset
//                  e_mdu_en, e_mdu_op  E-stage MDU op valid and op code
//                  e_rs, e_rt          forwarded operands
//                  d_mdu_use           D-stage instruction uses the MDU
//                  cancel              (MDU_CANCEL_EN only) exception flush
//                  start, busy, stall_d  control outputs
//                  mf_data             mfhi/mflo read data
//                  hi, lo              architectural HI/LO
//                Optional feature macro: MDU_CANCEL_EN. It adds the cancel port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_mdu_en,
    input  logic [2:0]  e_mdu_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_mdu_use,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        start,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [MDU_CNT_W-1:0] c_mult_cnt = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] c_div_cnt  = MDU_CNT_W'(DIV_CYCLES);

    logic [0:0]           r_state;
    logic [MDU_CNT_W-1:0] r_cnt;
    logic                 r_busy;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;

    logic                 w_cancel;
    logic                 w_idle;
    logic                 w_start;
    logic                 w_mt;
    logic                 w_is_div;
    logic [31:0]          w_next_hi;
    logic [31:0]          w_next_lo;

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_idle   = (r_state == MDU_IDLE);
    // A cancel in the same cycle kills both a start and an mthi/mtlo write.
    assign w_start  = e_mdu_en & is_md_op(e_mdu_op) & w_idle & ~w_cancel;
    assign w_mt     = e_mdu_en & ((e_mdu_op == MD_MTHI) | (e_mdu_op == MD_MTLO))
                      & w_idle & ~w_cancel;
    assign w_is_div = (e_mdu_op == MD_DIV) | (e_mdu_op == MD_DIVU);

    mdu_arith u_arith (
        .op      (e_mdu_op),
        .rs      (e_rs),
        .rt      (e_rt),
        .cur_hi  (r_hi),
        .cur_lo  (r_lo),
        .next_hi (w_next_hi),
        .next_lo (w_next_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= MDU_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (w_start) begin
                        r_pend_hi <= w_next_hi;
                        r_pend_lo <= w_next_lo;
                        r_cnt     <= w_is_div ? c_div_cnt : c_mult_cnt;
                        r_busy    <= 1'b1;
                        r_state   <= MDU_BUSY;
                    end else if (w_mt) begin
                        r_hi <= w_next_hi;
                        r_lo <= w_next_lo;
                    end
                end
                MDU_BUSY: begin
                    // An E-stage MDU op arriving here is ignored. stall_d
                    // keeps it from reaching E.
                    if (w_cancel) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= MDU_IDLE;
                    end else if (r_cnt == MDU_CNT_W'(1)) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= MDU_IDLE;
                    end else begin
                        r_cnt <= r_cnt - MDU_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= MDU_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mf_data = 32'd0;
        if (e_mdu_op == MD_MFHI)      mf_data = r_hi;
        else if (e_mdu_op == MD_MFLO) mf_data = r_lo;
    end

    assign start   = w_start;
    assign busy    = r_busy;
    // stall_d includes start so that the op right behind a start is held.
    assign stall_d = d_mdu_use & (w_start | r_busy);
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Self-checking bench for mdu_ctrl. It combines directed cases
//                with randomized traffic. A cycle-count reference model
//                checks the results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MDU_CANCEL_EN
    localparam bit CANCEL_ON = 1'b1;
`else
    localparam bit CANCEL_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        e_mdu_en;
    logic [2:0]  e_mdu_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_mdu_use;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    logic        start;
    logic        busy;
    logic        stall_d;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_mdu_en  (e_mdu_en),
        .e_mdu_op  (e_mdu_op),
        .e_rs      (e_rs),
        .e_rt      (e_rt),
        .d_mdu_use (d_mdu_use),
`ifdef MDU_CANCEL_EN
        .cancel    (cancel),
`endif
        .start     (start),
        .busy      (busy),
        .stall_d   (stall_d),
        .mf_data   (mf_data),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: remaining busy cycles plus architectural/pending values
    int          m_left;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Architectural {hi,lo} after an op, from plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] rs,
                                               input logic [31:0] rt, input logic [31:0] h,
                                               input logic [31:0] l);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ua = {32'd0, rs};
        ub = {32'd0, rt};
        case (op)
            3'd0: return sa * sb;
            3'd1: return ua * ub;
            3'd2: begin
                if (sb == 0) return {h, l};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (ub == 0) return {h, l};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3'd6: return {rs, l};
            3'd7: return {h, rs};
            default: return {h, l};
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_left = 0;
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
    endtask

    // One pipeline cycle: drive, check mid-cycle, then advance the model.
    task automatic step(input logic en, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic du, input logic cx);
        logic        ce, x_start, x_mt, x_busy;
        logic [31:0] x_mf;
        logic [63:0] res;
        @(negedge clk);
        e_mdu_en  = en;
        e_mdu_op  = op;
        e_rs      = rs;
        e_rt      = rt;
        d_mdu_use = du;
`ifdef MDU_CANCEL_EN
        cancel    = cx;
`endif
        ce      = cx & CANCEL_ON;
        x_busy  = (m_left != 0);
        x_start = en && (op <= 3'd3) && !x_busy && !ce;
        x_mt    = en && (op >= 3'd6) && !x_busy && !ce;
        x_mf    = (op == 3'd4) ? m_hi : ((op == 3'd5) ? m_lo : 32'd0);
        assert (!(en && x_busy)) else $error("bench drove an MDU op while busy");
        #1;
        chk("start",   start,   x_start);
        chk("busy",    busy,    x_busy);
        chk("stall_d", stall_d, du && (x_start || x_busy));
        chk("mf_data", mf_data, x_mf);
        chk("hi",      hi,      m_hi);
        chk("lo",      lo,      m_lo);
        @(posedge clk);
        if (x_busy) begin
            if (ce) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
            end
        end else if (x_start) begin
            res = ref_result(op, rs, rt, m_hi, m_lo);
            m_phi = res[63:32];
            m_plo = res[31:0];
            m_left = (op == 3'd2 || op == 3'd3) ? DIV_N : MULT_N;
        end else if (x_mt) begin
            res = ref_result(op, rs, rt, m_hi, m_lo);
            m_hi = res[63:32];
            m_lo = res[31:0];
        end
    endtask

    task automatic idle(input int n, input logic du);
        for (int i = 0; i < n; i++) step(1'b0, 3'd4, 32'd0, 32'd0, du, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; e_mdu_en = 1'b0; e_mdu_op = 3'd0; e_rs = '0; e_rt = '0;
        d_mdu_use = 1'b0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // mult -2 * 3
        step(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        idle(MULT_N, 1'b0);
        #1;
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // multu with mfhi waiting in D for the whole busy window
        step(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        idle(MULT_N, 1'b1);
        step(1'b1, 3'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("multu_mfhi", mf_data, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // div -7 / 2, then divu by zero holds HI/LO
        step(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        #1;
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        step(1'b1, 3'd3, 32'd12345, 32'd0, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        #1;
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);

        // signed overflow divide
        step(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        #1;
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0000_0000);

        // mthi then mflo back-to-back
        step(1'b1, 3'd6, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        #1;
        chk("mthi_hi", hi, 32'h1234_5678);
        step(1'b1, 3'd5, 32'd0, 32'd0, 1'b0, 1'b0);

        // asynchronous reset during busy cycle 3 of a divide
        step(1'b1, 3'd7, 32'h0000_0055, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd2, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(2, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(1, 1'b1);

`ifdef MDU_CANCEL_EN
        step(1'b1, 3'd6, 32'h0000_000A, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd7, 32'h0000_000B, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'd3, 32'd4, 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 3'd4, 32'd0, 32'd0, 1'b0, 1'b1);
        #1;
        chk("cxl_busy", busy, 1'b0);
        chk("cxl_hi", hi, 32'h0000_000A);
        chk("cxl_lo", lo, 32'h0000_000B);
        step(1'b1, 3'd0, 32'd3, 32'd4, 1'b0, 1'b1);
        step(1'b1, 3'd6, 32'd99, 32'd0, 1'b0, 1'b1);
        #1;
        chk("cxl_mt_hi", hi, 32'h0000_000A);
`endif

        // randomized traffic, never issuing an MDU op while busy
        for (int i = 0; i < 600; i++) begin
            logic en;
            en = (m_left == 0) && ($urandom_range(0, 2) != 0);
            step(en, 3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequences the multiply/divide unit (MDU) of the P6 five-stage MIPS pipeline and owns the HI/LO registers.
- Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from E stage, selected by the decoder's aluSel=1 with ALUOP 0..7.
- Models fixed multi-cycle latency with a busy counter.
- Drives the D-stage stall whenever an MDU instruction would collide with an op in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- e_mdu_en  in  1  E-stage instruction is an MDU op (aluSel & E valid)
- e_mdu_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo
- e_rs  in  32  forwarded rs operand
- e_rt  in  32  forwarded rt operand
- d_mdu_use  in  1  D-stage instruction is md|mf|mt
- start  out  1  combinational; e_mdu_en & op<=3 & state==IDLE
- busy  out  1  registered; high while an op is in flight
- stall_d  out  1  combinational; d_mdu_use & (start | busy)
- mf_data  out  32  combinational; HI for op 4, LO for op 5, else 0
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset is asynchronous, active-high: state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending registers=0. If reset hits mid-operation, the op is discarded and HI/LO read 0.
- States are IDLE and BUSY.
- IDLE & start:
  - Latch results at the edge: op0 {hi,lo}=signed rs*rt; op1 unsigned product; op2 lo=signed rs/rt, hi=signed rs%rt; op3 unsigned quotient/remainder.
  - Latched values go to pend_hi/pend_lo. Load cnt=MULT_CYCLES or DIV_CYCLES. Go to BUSY.
- BUSY: cnt decrements each edge. When cnt==1, the next edge copies pend_hi/pend_lo into hi/lo, clears busy and returns to IDLE.
- Visible timing: start in cycle T; busy high in cycles T+1..T+N; new HI/LO visible from cycle T+N+1.
- Divide by zero (op2/op3 with rt==0): timing is unchanged and HI/LO keep their prior values (pending is loaded from current hi/lo).
- mthi/mtlo (op 6/7) with e_mdu_en in IDLE write hi/lo at the edge. Latency 1; no busy.
- mfhi/mflo return the current architectural hi/lo combinationally. stall_d guarantees no mf reaches E while start|busy.
- An MDU op in E while busy is a protocol violation, made impossible by stall_d. The block must ignore it (no state change). Verification asserts it never happens.
- Signed division follows two's-complement truncation toward zero. 0x80000000 / -1 gives lo=0x80000000, hi=0.
- start is independent of d_mdu_use. In the same cycle a start occurs, stall_d is already asserted for a following MDU op.

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit).
  - cancel high in BUSY returns to IDLE at the next edge with busy=0 and hi/lo unchanged.
  - cancel high together with start suppresses the start and any mthi/mtlo write.
  - Used for the exception flush.
- Undefined: no cancel port; every started op always completes.

Decomposition:
- Shared package/header holds:
  - the MDU op encodings (MD_MULT=0 … MD_MTLO=7), matching the decoder's ALUOP values under aluSel=1
  - the state encodings MDU_IDLE and MDU_BUSY
  - the default latencies
- One natural sub-module: mdu_arith, purely combinational. Takes op, rs, rt, cur_hi and cur_lo; returns next_hi and next_lo, including the divide-by-zero hold. mdu_ctrl keeps the FSM, counter, pending and architectural registers.

Test Plan:
- mult rs=0xFFFFFFFE (−2), rt=3 → start 1 cycle; busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu rs=0xFFFFFFFF, rt=2 → after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE; mfhi in D during busy sees stall_d=1 for every busy cycle and reads 1 once released.
- div rs=−7, rt=2 → busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rt=0 → hi/lo unchanged after 10 cycles.
- mthi 0x12345678 then mflo back-to-back → hi updates next cycle, no stall, mf_data=lo.
- Assert reset at busy cycle 3 of div → busy=0, hi=lo=0 immediately (asynchronous), IDLE next cycle.
- With MDU_CANCEL_EN: cancel at busy cycle 2 of mult with old hi=0xA, lo=0xB → busy drops next edge, hi=0xA, lo=0xB retained.
